// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command path: opcodes, command width,
// cmd_data field positions and the command-filter predicate.
package alsu_pkg;

  localparam int CMD_W = 16;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_XOR    = 3'd1;
  localparam logic [2:0] OP_ADD    = 3'd2;
  localparam logic [2:0] OP_MULT   = 3'd3;
  localparam logic [2:0] OP_SHIFT  = 3'd4;
  localparam logic [2:0] OP_ROTATE = 3'd5;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int A_HI   = 12;
  localparam int A_LO   = 10;
  localparam int B_HI   = 9;
  localparam int B_LO   = 7;
  localparam int CIN_B  = 6;
  localparam int SIN_B  = 5;
  localparam int DIR_B  = 4;
  localparam int RA_B   = 3;
  localparam int RB_B   = 2;
  localparam int BA_B   = 1;
  localparam int BB_B   = 0;

  // Commands the ALSU cannot execute meaningfully: undefined opcodes (above
  // ROTATE), or a reduction request on an opcode other than AND/XOR.
  function automatic logic cmd_filtered(input logic [CMD_W-1:0] c);
    logic [2:0] opc;
    opc = c[OPC_HI:OPC_LO];
    return (opc > OP_ROTATE) || ((c[RA_B] | c[RB_B]) && (opc > OP_XOR));
  endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Synchronous command FIFO with push/pop/flush and exact occupancy level.
// Flush (and reset) clear pointers and level; storage is not cleared.
module alsu_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [LVL_W-1:0] lvl_q;

  // Pointer and level bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + LVL_W'(1);
        2'b01:   lvl_q <= lvl_q - LVL_W'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // Storage write; callers never push during flush or when full.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign full  = (lvl_q == LVL_W'(DEPTH));
  assign empty = (lvl_q == '0);
  assign level = lvl_q;

endmodule

// File: rtl/alsu_cmd_seq.sv
// ALSU command sequencer: buffers packed commands and issues one per cycle
// onto registered ALSU pins with an issue strobe and rolling tag.
// Optional feature: define ALSU_SEQ_FILTER_EN to discard unexecutable
// commands at pop time (drop pulse + saturating drop counter).
module alsu_cmd_seq
  import alsu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [CMD_W-1:0]             cmd_data,
  input  logic                         pause,
  input  logic                         flush,
  output logic [2:0]                   opcode,
  output logic [2:0]                   A,
  output logic [2:0]                   B,
  output logic                         cin,
  output logic                         serial_in,
  output logic                         direction,
  output logic                         red_op_A,
  output logic                         red_op_B,
  output logic                         bypass_A,
  output logic                         bypass_B,
  output logic                         issue_valid,
  output logic [TAG_W-1:0]             issue_tag,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         drop,
  output logic [7:0]                   drop_cnt
);
  logic             full, empty, push, pop, filt;
  logic [CMD_W-1:0] head;
  logic [CMD_W-1:0] pins_q;
  logic [TAG_W-1:0] tag_q;
  logic             iv_q;

  // Ready looks only at registered fullness and flush, never at cmd_valid.
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !pause && !flush && !empty;

  alsu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (cmd_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef ALSU_SEQ_FILTER_EN
  logic       drop_q;
  logic [7:0] drop_cnt_q;

  assign filt = cmd_filtered(head);

  // A filtered command still consumes its pop slot; count it, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q <= pop && filt;
      if (pop && filt && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop     = drop_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign filt     = 1'b0;
  assign drop     = 1'b0;
  assign drop_cnt = '0;
`endif

  // Issue register: load pins and bump tag only on a real (unfiltered) issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pins_q <= '0;
      tag_q  <= '0;
      iv_q   <= 1'b0;
    end else begin
      iv_q <= pop && !filt;
      if (pop && !filt) begin
        pins_q <= head;
        tag_q  <= tag_q + TAG_W'(1);
      end
    end
  end

  assign opcode      = pins_q[OPC_HI:OPC_LO];
  assign A           = pins_q[A_HI:A_LO];
  assign B           = pins_q[B_HI:B_LO];
  assign cin         = pins_q[CIN_B];
  assign serial_in   = pins_q[SIN_B];
  assign direction   = pins_q[DIR_B];
  assign red_op_A    = pins_q[RA_B];
  assign red_op_B    = pins_q[RB_B];
  assign bypass_A    = pins_q[BA_B];
  assign bypass_B    = pins_q[BB_B];
  assign issue_valid = iv_q;
  assign issue_tag   = tag_q;

endmodule

// File: tb/tb_alsu_cmd_seq.sv
// Bench for alsu_cmd_seq: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a queue-based model.
module tb_alsu_cmd_seq;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic        pause = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  opcode, A, B;
  logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic        issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic [3:0]  level;
  logic        drop;
  logic [7:0]  drop_cnt;
  logic [15:0] pins;

  assign pins = {opcode, A, B, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B};

  alsu_cmd_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .pause(pause), .flush(flush),
    .opcode(opcode), .A(A), .B(B), .cin(cin), .serial_in(serial_in),
    .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .issue_valid(issue_valid),
    .issue_tag(issue_tag), .level(level), .drop(drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_q[$];
  logic [15:0] m_pins;
  int          m_tag, m_dcnt;
  bit          m_iv, m_drop;

  function automatic bit m_filt(input logic [15:0] c);
`ifdef ALSU_SEQ_FILTER_EN
    int op;
    op = int'(c[15:13]);
    return (op == 6 || op == 7) || ((c[3] || c[2]) && op > 1);
`else
    return (c === 16'hxxxx);
`endif
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_pins = '0; m_tag = 0; m_dcnt = 0; m_iv = 0; m_drop = 0;
  endtask

  task automatic m_edge(input bit v, input logic [15:0] d, input bit p, input bit f);
    bit rdy;
    logic [15:0] c;
    rdy = (m_q.size() < DEPTH) && !f;
    m_iv = 0; m_drop = 0;
    if (f) m_q.delete();
    else begin
      if (!p && m_q.size() > 0) begin
        c = m_q.pop_front();
        if (m_filt(c)) begin
          m_drop = 1;
          if (m_dcnt < 255) m_dcnt++;
        end else begin
          m_iv = 1; m_pins = c; m_tag = (m_tag + 1) % (1 << TAG_W);
        end
      end
      if (v && rdy) m_q.push_back(d);
    end
  endtask

  task automatic cmp_outputs(input string pfx);
    chk({pfx, "_iv"},    issue_valid, m_iv);
    chk({pfx, "_tag"},   issue_tag, m_tag);
    chk({pfx, "_level"}, level, m_q.size());
    chk({pfx, "_pins"},  pins, m_pins);
    chk({pfx, "_drop"},  drop, m_drop);
    chk({pfx, "_dcnt"},  drop_cnt, m_dcnt);
  endtask

  // One clock: drive at negedge, check ready, then check outputs after edge.
  task automatic step(input bit v, input logic [15:0] d, input bit p, input bit f,
                      output bit rdy);
    @(negedge clk);
    cmd_valid = v; cmd_data = d; pause = p; flush = f;
    #1;
    rdy = cmd_ready;
    chk("ready", cmd_ready, (m_q.size() < DEPTH) && !f);
    @(posedge clk);
    #1;
    m_edge(v, d, p, f);
    cmp_outputs("mdl");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 0; pause = 0; flush = 0;
    @(posedge clk);
    #1;
    m_reset();
    chk("rst_pins", pins, 16'h0);
    chk("rst_iv", issue_valid, 1'b0);
    chk("rst_tag", issue_tag, 0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop, 1'b0);
    chk("rst_dcnt", drop_cnt, 0);
    chk("rst_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          p;
    bit          f;
    bit          e_rdy;
    bit          e_iv;
    int          e_tag;
    int          e_lvl;
    logic [15:0] e_pins;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, logic [15:0] d, bit p, bit f, bit er, bit ei,
                              int et, int el, logic [15:0] ep);
    vec_t r;
    r.v = v; r.d = d; r.p = p; r.f = f;
    r.e_rdy = er; r.e_iv = ei; r.e_tag = et; r.e_lvl = el; r.e_pins = ep;
    return r;
  endfunction

  initial begin
    bit rdy;
    int n_iv, n_drop;
    logic [15:0] c1, hold;

    // {opcode=2, A=5, B=1, cin=1}
    c1 = 16'h54C0;
    tbl.push_back(mk(1, c1, 0, 0, 1, 0, 0, 1, 16'h0));
    tbl.push_back(mk(0, 0,  0, 0, 1, 1, 1, 0, c1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 0, 1, 0, c1));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 16'(k << 7), 1, 0, 1, 0, 1, k, c1));
    tbl.push_back(mk(1, 16'hFFFF, 1, 0, 0, 0, 1, 8, c1));        // 9th refused
    tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 1, 2, 7, 16'h0080));  // full: pop, no push
    for (int k = 2; k <= 8; k++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, k + 1, 8 - k, 16'(k << 7)));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 9, 0, 16'h0400));

    m_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Directed vector table
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].f, rdy);
      chk($sformatf("tbl%0d_rdy", i),  rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_iv", i),   issue_valid, tbl[i].e_iv);
      chk($sformatf("tbl%0d_tag", i),  issue_tag, tbl[i].e_tag);
      chk($sformatf("tbl%0d_lvl", i),  level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_pins", i), pins, tbl[i].e_pins);
    end

    // Back-to-back: 18 issues starting from tag 9 wraps through 15->0
    for (int i = 0; i < 18; i++) step(1, 16'((i % 8) << 7), 0, 0, rdy);
    step(0, 0, 0, 0, rdy);
    chk("wrap_tag", issue_tag, 11);

    // Flush with 5 queued plus a same-cycle push
    hold = m_pins;
    for (int i = 0; i < 5; i++) step(1, 16'h0100 + 16'(i), 1, 0, rdy);
    chk("flush_pre_lvl", level, 5);
    step(1, 16'h0200, 1, 1, rdy);
    chk("flush_rdy", rdy, 1'b0);
    chk("flush_lvl", level, 0);
    chk("flush_iv", issue_valid, 1'b0);
    chk("flush_pins", pins, hold);
    step(0, 0, 0, 0, rdy);
    chk("flush_post_iv", issue_valid, 1'b0);

    // Reset mid-stream discards queued commands
    for (int i = 0; i < 3; i++) step(1, 16'h0300 + 16'(i), 1, 0, rdy);
    do_reset();
    step(0, 0, 0, 0, rdy);
    chk("midrst_iv", issue_valid, 1'b0);
    chk("midrst_lvl", level, 0);

    // Filter candidates: opcode 6; opcode 3 + red_op_A; opcode 1 + red_op_B
    step(1, 16'hC000, 1, 0, rdy);
    step(1, 16'h6008, 1, 0, rdy);
    step(1, 16'h2004, 1, 0, rdy);
    n_iv = 0; n_drop = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, rdy);
      n_iv += int'(issue_valid);
      n_drop += int'(drop);
    end
`ifdef ALSU_SEQ_FILTER_EN
    chk("filt_issues", n_iv, 1);
    chk("filt_drops", n_drop, 2);
    chk("filt_dcnt", drop_cnt, 2);
    chk("filt_tag", issue_tag, 1);
`else
    chk("filt_issues", n_iv, 3);
    chk("filt_drops", n_drop, 0);
    chk("filt_dcnt", drop_cnt, 0);
    chk("filt_tag", issue_tag, 3);
`endif
    chk("filt_pins", pins, 16'h2004);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, 16'($urandom), ($urandom % 4) == 0,
           ($urandom % 20) == 0, rdy);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alsu_cmd_seq.md
# alsu_cmd_seq

Command sequencer sitting directly upstream of the ALSU. Accepts packed ALSU commands over a valid/ready handshake and buffers them in a synchronous FIFO. Presents one command per cycle on registered outputs that wire 1:1 to the ALSU input pins, with an issue strobe and a rolling tag so downstream logic can match results to commands.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- TAG_W, 4: width of issue_tag.

- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  sequencer can accept; equals !full && !flush.
- cmd_data  in  16  packed command: [15:13] opcode, [12:10] A, [9:7] B, [6] cin, [5] serial_in, [4] direction, [3] red_op_A, [2] red_op_B, [1] bypass_A, [0] bypass_B.
- pause  in  1  holds issue; FIFO still accepts.
- flush  in  1  empties FIFO synchronously.
- opcode, A, B  out  3 each  to ALSU.
- cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  out  1 each  to ALSU.
- issue_valid  out  1  high for the cycle a newly issued command is on the ALSU pins.
- issue_tag  out  TAG_W  tag of the command on the pins; increments per issued command, wraps.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- drop  out  1  one-cycle pulse when a command is filtered (see Configuration).
- drop_cnt  out  8  filtered-command count, saturates at 255.

## Operation
- Push: cmd_valid && cmd_ready at an edge writes cmd_data to tail.
- Pop: at each edge where !pause && !flush && !empty, head is removed and (if not filtered) registered onto ALSU pins; issue_valid=1, issue_tag increments, for the following cycle.
- No pop: ALSU pins hold last issued values; issue_valid=0; tag unchanged.
- Simultaneous push and pop: both occur; level unchanged. When full, cmd_ready=0 even if a pop occurs that cycle (no pass-through).
- Flush: FIFO pointers and level cleared at the edge; any same-cycle push is refused (cmd_ready=0); no pop that cycle; pins and tag hold.
- Pause and flush together: flush applies.
- Pointers wrap modulo DEPTH; level tracks 0..DEPTH exactly.
- Reset: all pin outputs 0, issue_valid 0, issue_tag 0, level 0, drop 0, drop_cnt 0, cmd_ready 1 after the reset edge. Reset mid-stream discards all queued commands.

## Timing
- Minimum latency: command accepted at edge N on empty FIFO is popped at edge N+1 and visible on the pins (issue_valid=1) during cycle N+1..N+2.
- Sustained throughput: one command per cycle.
- cmd_ready is combinational from registered full state and the flush input only; it never depends on cmd_valid.
- level updates at the same edge as the push/pop it reflects.
- drop asserts in the cycle following the popping edge, aligned with where issue_valid would have been.

## Configuration
- ALSU_SEQ_FILTER_EN defined: at pop, a command with opcode 6 or 7, or with red_op_A|red_op_B set while opcode > 1, is discarded. It consumes the pop slot; pins, tag and issue_valid behave as no-pop. drop pulses and drop_cnt increments, saturating.
- Undefined: every command is issued unchanged; drop tied 0, drop_cnt tied 0.

## Structure
- Package alsu_pkg: opcode constants OP_AND=0, OP_XOR=1, OP_ADD=2, OP_MULT=3, OP_SHIFT=4, OP_ROTATE=5; CMD_W=16; field bit-position constants for cmd_data.
- Sub-module alsu_cmd_fifo: synchronous FIFO with push/pop/flush, full/empty, level. Issue register, tag and filter live in alsu_cmd_seq.

## Test plan
- Reset, then push {opcode=2,A=5,B=1,cin=1} once → next cycle pins show opcode=2,A=5,B=1,cin=1, issue_valid=1, issue_tag=1; then issue_valid=0, pins hold.
- Pause high, push 8 commands → level=8, cmd_ready=0. 9th cmd_valid refused. Release pause → 8 consecutive issue_valid cycles in push order, tags 1..8.
- Full FIFO, pop and push in the same cycle → push refused, level 8→7.
- 17 back-to-back issues with TAG_W=4 → tag wraps 15→0→1.
- Flush with 5 queued plus a same-cycle push → level=0 next cycle, no issue, pins hold last values.
- With ALSU_SEQ_FILTER_EN, push opcode=6, then opcode=3 with red_op_A=1, then opcode=1 with red_op_B=1 → two drop pulses (drop_cnt=2), only the third issued. Without the macro → all three issued, drop_cnt=0.
